// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary PWM generator with dead-time insertion.
// A free-running period counter is compared against a period-latched duty
// value to drive the high-side (T1) and low-side (T2) gates. Both gates are
// registered, and a DEADTIME band precedes every turn-on. Because T1 needs
// cnt < d_sh and T2 needs cnt >= d_sh + DEADTIME, the two gates can never be
// high in the same cycle.
// Optional feature: define PWM_DT_PERIOD_TICK_EN to add the period_tick output,
// a one-cycle pulse at the start of every period, for ADC/control-loop sync.
module pwm_deadtime #(
  parameter int WIDTH    = 10,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             T1,
  output logic             T2
`ifdef PWM_DT_PERIOD_TICK_EN
  ,
  output logic             period_tick
`endif
);

  // All compares use WIDTH+1 bits. PERIOD may equal 2**WIDTH, and
  // d_sh + DEADTIME must not wrap.
  localparam logic [WIDTH:0] LP_PERIOD = (WIDTH+1)'(PERIOD);
  localparam logic [WIDTH:0] LP_DEAD   = (WIDTH+1)'(DEADTIME);
  localparam logic [WIDTH:0] LP_LAST   = LP_PERIOD - (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_d_sh;
  logic             r_t1;
  logic             r_t2;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_d_clamp;
  logic [WIDTH:0]   w_t2_start;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_last;
  logic             w_t1_next;
  logic             w_t2_next;

  // Clamp the duty command, advance the counter, and evaluate the next gate states.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    w_cnt_ext  = {1'b0, r_cnt};
    w_d_clamp  = ({1'b0, d} > LP_PERIOD) ? LP_PERIOD : {1'b0, d};
    w_t2_start = r_d_sh + LP_DEAD;
    w_last     = (w_cnt_ext == LP_LAST);
    w_cnt_next = w_last ? '0 : r_cnt + WIDTH'(1);
    w_t1_next  = en && (w_cnt_ext >= LP_DEAD) && (w_cnt_ext < r_d_sh);
    w_t2_next  = en && (w_cnt_ext >= w_t2_start) && (w_cnt_ext <= LP_LAST);
  end

  // Counter, duty shadow and registered gates. The duty shadow is reloaded
  // only at the period boundary, so a duty change cannot glitch a pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      r_cnt  <= '0;
      r_d_sh <= '0;
      r_t1   <= 1'b0;
      r_t2   <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_d_sh <= w_d_clamp;
      r_t1   <= 1'b0;
      r_t2   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_last) begin
        r_d_sh <= w_d_clamp;
      end
      r_t1 <= w_t1_next;
      r_t2 <= w_t2_next;
    end
  end

  assign T1 = r_t1;
  assign T2 = r_t2;

`ifdef PWM_DT_PERIOD_TICK_EN
  logic r_tick;

  // Registered sync pulse: high for one cycle after each cnt==0 while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= en && (r_cnt == '0);
    end
  end

  assign period_tick = r_tick;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed bench for pwm_deadtime at its defaults
// (WIDTH=10, PERIOD=1000, DEADTIME=50). Expected values are hand-computed.
// The measurement windows start at a period start, so sample index i shows
// the gate state computed from cnt=i.
module tb_pwm_deadtime;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] d;
  logic             T1;
  logic             T2;
`ifdef PWM_DT_PERIOD_TICK_EN
  logic             period_tick;
  int               ticks;
`endif

  int total = 0;
  int bad   = 0;
  int overlaps = 0;

  pwm_deadtime #(.WIDTH(WIDTH), .PERIOD(1000), .DEADTIME(50)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .d    (d),
    .T1   (T1),
    .T2   (T2)
`ifdef PWM_DT_PERIOD_TICK_EN
    ,
    .period_tick(period_tick)
`endif
  );

  always #5 clk = ~clk;

  // Invariant watch: both gates high in the same cycle is never allowed.
  always @(negedge clk) begin
    if (T1 === 1'b1 && T2 === 1'b1) overlaps++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run n cycles and sample each one after its rising edge. Reports the
  // high counts and the first and last high indices (-1 if never high).
  task automatic measure(input int n, output int c1, output int c2,
                         output int f1, output int l1,
                         output int f2, output int l2);
    c1 = 0; c2 = 0; f1 = -1; l1 = -1; f2 = -1; l2 = -1;
`ifdef PWM_DT_PERIOD_TICK_EN
    ticks = 0;
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (T1 === 1'b1) begin
        c1++;
        if (f1 < 0) f1 = i;
        l1 = i;
      end
      if (T2 === 1'b1) begin
        c2++;
        if (f2 < 0) f2 = i;
        l2 = i;
      end
`ifdef PWM_DT_PERIOD_TICK_EN
      if (period_tick === 1'b1) ticks++;
`endif
    end
  endtask

  initial begin
    int c1, c2, f1, l1, f2, l2;
    int a1, a2;

    // Reset held for 3 cycles with en=1 and d=500: both gates stay off.
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 10'd500;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_T1", int'(T1), 0);
      check("reset_T2", int'(T2), 0);
    end

    // Release reset with en=0 so the shadow duty picks up d=500.
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("idle_T1", int'(T1), 0);
    check("idle_T2", int'(T2), 0);

    // Period 1 with d=500: T1 at cnt 50..499, T2 at cnt 550..999.
    en = 1'b1;
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d500_T1_cnt", c1, 450);
    check("d500_T1_first", f1, 50);
    check("d500_T1_last", l1, 499);
    check("d500_T2_cnt", c2, 450);
    check("d500_T2_first", f2, 550);
    check("d500_T2_last", l2, 999);
`ifdef PWM_DT_PERIOD_TICK_EN
    check("tick_per_period", ticks, 1);
`endif

    // d=1 is set at the start of a period, so that period still runs at 500.
    d = 10'd1;
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d1_pending_T1_cnt", c1, 450);
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d1_T1_cnt", c1, 0);
    check("d1_T2_cnt", c2, 949);
    check("d1_T2_first", f2, 51);
    check("d1_T2_last", l2, 999);

    // d=100: T1 at cnt 50..99, T2 at cnt 150..999.
    d = 10'd100;
    measure(1000, c1, c2, f1, l1, f2, l2);
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d100_T1_cnt", c1, 50);
    check("d100_T1_first", f1, 50);
    check("d100_T1_last", l1, 99);
    check("d100_T2_cnt", c2, 850);
    check("d100_T2_first", f2, 150);

    // d=999: T1 at cnt 50..998 and T2 stays off.
    d = 10'd999;
    measure(1000, c1, c2, f1, l1, f2, l2);
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d999_T1_cnt", c1, 949);
    check("d999_T1_last", l1, 998);
    check("d999_T2_cnt", c2, 0);

    // d=1023 clamps to 1000: T1 at cnt 50..999 and T2 stays off.
    d = 10'd1023;
    measure(1000, c1, c2, f1, l1, f2, l2);
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("d1023_T1_cnt", c1, 950);
    check("d1023_T1_last", l1, 999);
    check("d1023_T2_cnt", c2, 0);

    // d goes from 100 to 500 at cnt 300: that period keeps 100, the next uses 500.
    d = 10'd100;
    measure(1000, c1, c2, f1, l1, f2, l2);
    measure(300, c1, c2, f1, l1, f2, l2);
    a1 = c1;
    a2 = c2;
    d = 10'd500;
    measure(700, c1, c2, f1, l1, f2, l2);
    check("midchg_T1_cnt", a1 + c1, 50);
    check("midchg_T2_cnt", a2 + c2, 850);
    measure(1000, c1, c2, f1, l1, f2, l2);
    check("midchg_next_T1_cnt", c1, 450);
    check("midchg_next_T2_cnt", c2, 450);

    // Drop en in the middle of T1 (cnt 199): both gates go off on the next edge.
    measure(200, c1, c2, f1, l1, f2, l2);
    check("pre_drop_T1", int'(T1), 1);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_T1", int'(T1), 0);
    check("drop_T2", int'(T2), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);

    // Raise en again: the period restarts at cnt 0, so T1 first shows at
    // sample 50, which is 51 edges after en rises.
    en = 1'b1;
    measure(60, c1, c2, f1, l1, f2, l2);
    check("rerise_T1_first", f1, 50);
    check("rerise_T1_cnt", c1, 10);
    check("rerise_T2_cnt", c2, 0);

    check("no_overlap", overlaps, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
